memory_stage: RTL and testbench

- Y86-64 pipeline memory stage, directly downstream of the execute stage.
- Consumes the M pipeline register (M_icode, M_valE, M_valA, M_dstE, M_dstM, M_stat).
- Performs the 8-byte data-memory read or write, produces m_valM and m_stat, and holds the W pipeline register that feeds decode/write-back.
- Owns the byte-addressable data memory and a bench preload port.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/data_memory.sv | 39 +++
 rtl/memory_stage.sv | 112 +++++++++++
 tb/tb_memory_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 icode, status and register encodings.
// Revision    : 1.0
// ============================================================================
package y86_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] RRMOVQ = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [3:0] AOK    = 4'h1;
    localparam logic [3:0] HLT    = 4'h2;
    localparam logic [3:0] ADR    = 4'h3;
    localparam logic [3:0] INS    = 4'h4;

    localparam logic [3:0] RNONE  = 4'hF;

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == MRMOVQ) || (icode == POPQ) || (icode == RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == RMMOVQ) || (icode == PUSHQ) || (icode == CALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte array, one combinational 8-byte read, one 8-byte write.
// Revision    : 1.0
// ============================================================================
module data_memory #(
    parameter int MEM_BYTES = 4096,
    parameter int IDX_W     = $clog2(MEM_BYTES)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic             wr_in_range,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [63:0]      wr_data
);

    logic [7:0] mem [MEM_BYTES];

    // Little-endian: byte k of the word lives at address idx+k.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = mem[rd_idx + IDX_W'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            for (int k = 0; k < 8; k++) begin
                mem[wr_idx + IDX_W'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Y86-64 memory stage: data access, status and the W register.
// Revision    : 1.0
// ============================================================================
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [ADDR_W-1:0] M_valE,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    input  logic              pl_we,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [ADDR_W-1:0] pl_data,
    output logic [ADDR_W-1:0] m_valM,
    output logic [3:0]        m_stat,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [ADDR_W-1:0] W_valE,
    output logic [ADDR_W-1:0] W_valM
);

    localparam int                IDX_W   = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic              dmem_error;
    logic [63:0]       rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [63:0]       wr_data;
    logic              unused_cnd;

    assign unused_cnd = M_cnd;

    assign mem_read  = is_mem_read(M_icode);
    assign mem_write = is_mem_write(M_icode);

    always_comb begin
        mem_addr = M_valE;
        if ((M_icode == RET) || (M_icode == POPQ)) begin
            mem_addr = M_valA;
        end
    end

    // Unsigned compare: wrapping or huge addresses fault as well.
    assign dmem_error = (mem_read || mem_write) && (mem_addr > LAST_OK);
    assign m_stat     = dmem_error ? ADR : M_stat;
    assign m_valM     = (mem_read && !dmem_error) ? rd_data : '0;

    // Preload owns the write port during reset, which also kills any store.
    always_comb begin
        if (rst) begin
            wr_en   = pl_we;
            wr_addr = pl_addr;
            wr_data = pl_data;
        end else begin
            wr_en   = mem_write && !dmem_error && (W_stat == AOK) && !W_stall;
            wr_addr = mem_addr;
            wr_data = M_valA;
        end
    end

    data_memory #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IDX_W)
    ) u_dmem (
        .clk         (clk),
        .rd_idx      (mem_addr[IDX_W-1:0]),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_in_range (wr_addr <= LAST_OK),
        .wr_idx      (wr_addr[IDX_W-1:0]),
        .wr_data     (wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst || (W_bubble && !W_stall)) begin
            W_stat  <= AOK;
            W_icode <= NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (!W_stall) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Directed scoreboard bench for memory_stage.
// Revision    : 1.0
// ============================================================================
module tb_memory_stage;
    import y86_pkg::*;

    localparam int MEM_BYTES = 4096;
    localparam logic [63:0] MEMB = 64'(MEM_BYTES);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  M_stat = AOK, M_icode = NOP, M_dstE = RNONE, M_dstM = RNONE;
    logic        M_cnd = 1'b0;
    logic [63:0] M_valE = '0, M_valA = '0;
    logic        W_stall = 1'b0, W_bubble = 1'b0, pl_we = 1'b0;
    logic [63:0] pl_addr = '0, pl_data = '0;
    logic [63:0] m_valM, W_valE, W_valM;
    logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;

    memory_stage #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .pl_we(pl_we), .pl_addr(pl_addr),
        .pl_data(pl_data), .m_valM(m_valM), .m_stat(m_stat), .W_stat(W_stat),
        .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE),
        .W_valM(W_valM)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_m;
        logic [63:0] valM;
        logic [3:0]  mstat;
        bit          chk_w;
        logic [3:0]  wstat, wicode, wdstE, wdstM;
        logic [63:0] wvalE, wvalM;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s: got 0x%0h required 0x%0h", nm, fld, act, exp);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.chk_m) begin
                check(e.name, "m_valM", m_valM, e.valM);
                check(e.name, "m_stat", {60'd0, m_stat}, {60'd0, e.mstat});
            end
            if (e.chk_w) begin
                check(e.name, "W_stat",  {60'd0, W_stat},  {60'd0, e.wstat});
                check(e.name, "W_icode", {60'd0, W_icode}, {60'd0, e.wicode});
                check(e.name, "W_valE",  W_valE, e.wvalE);
                check(e.name, "W_valM",  W_valM, e.wvalM);
                check(e.name, "W_dstE",  {60'd0, W_dstE},  {60'd0, e.wdstE});
                check(e.name, "W_dstM",  {60'd0, W_dstM},  {60'd0, e.wdstM});
            end
        end
    end

    task automatic drive(input string nm, input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm);
        @(posedge clk);
        #1;
        M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
        cur.name  = nm;
        cur.chk_m = 1'b0;
        cur.chk_w = 1'b0;
    endtask

    task automatic exp_m(input logic [63:0] v, input logic [3:0] s);
        cur.chk_m = 1'b1; cur.valM = v; cur.mstat = s;
    endtask

    task automatic exp_w(input logic [3:0] s, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        cur.chk_w = 1'b1; cur.wstat = s; cur.wicode = ic; cur.wvalE = ve;
        cur.wvalM = vm; cur.wdstE = de; cur.wdstM = dm;
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        drive("preload", AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        rst = 1'b1; pl_we = 1'b1; pl_addr = a; pl_data = d;
        exp_q.push_back(cur);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    initial begin
        preload(64'h100, 64'h1122334455667788);
        preload(64'h200, 64'h0);
        preload(64'h208, 64'h0);
        preload(64'h300, 64'h0);
        preload(64'h400, 64'h0);
        preload(MEMB - 8, 64'h0123456789ABCDEF);
        preload(MEMB - 4, 64'hFFFFFFFFFFFFFFFF);    // out of range: must be dropped whole

        drive("reset_state", AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        pl_we = 1'b0;
        exp_m(64'd0, AOK);
        exp_w(AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        exp_q.push_back(cur);

        drive("load_0x100", AOK, MRMOVQ, 64'h100, 64'd0, RNONE, 4'd3);
        rst = 1'b0;
        exp_m(64'h1122334455667788, AOK);
        exp_w(AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        exp_q.push_back(cur);

        drive("store_0x203", AOK, RMMOVQ, 64'h203, 64'hAABBCCDD00112233, RNONE, RNONE);
        exp_m(64'd0, AOK);
        exp_w(AOK, MRMOVQ, 64'h100, 64'h1122334455667788, RNONE, 4'd3);
        exp_q.push_back(cur);

        drive("raw_load_0x200", AOK, MRMOVQ, 64'h200, 64'd0, RNONE, 4'd4);
        exp_m(64'hDD00112233000000, AOK);
        exp_w(AOK, RMMOVQ, 64'h203, 64'd0, RNONE, RNONE);
        exp_q.push_back(cur);

        drive("popq_top", AOK, POPQ, MEMB, MEMB - 8, 4'd4, 4'd2);
        exp_m(64'h0123456789ABCDEF, AOK);
        exp_w(AOK, MRMOVQ, 64'h200, 64'hDD00112233000000, RNONE, 4'd4);
        exp_q.push_back(cur);

        drive("ret_overrun", AOK, RET, MEMB, MEMB - 7, 4'd4, RNONE);
        exp_m(64'd0, ADR);
        exp_w(AOK, POPQ, MEMB, 64'h0123456789ABCDEF, 4'd4, 4'd2);
        exp_q.push_back(cur);

        drive("push_after_adr", AOK, PUSHQ, 64'h300, 64'h55, 4'd4, RNONE);
        exp_m(64'd0, AOK);
        exp_w(ADR, RET, MEMB, 64'd0, 4'd4, RNONE);
        exp_q.push_back(cur);

        drive("push_stalled", AOK, PUSHQ, 64'h300, 64'h66, 4'd4, RNONE);
        W_stall = 1'b1;
        exp_m(64'd0, AOK);
        exp_w(AOK, PUSHQ, 64'h300, 64'd0, 4'd4, RNONE);
        exp_q.push_back(cur);

        drive("load_0x300", AOK, MRMOVQ, 64'h300, 64'd0, RNONE, 4'd5);
        W_stall = 1'b1; W_bubble = 1'b1;
        exp_m(64'd0, AOK);
        exp_w(AOK, PUSHQ, 64'h300, 64'd0, 4'd4, RNONE);
        exp_q.push_back(cur);

        drive("stall_over_bubble", AOK, OPQ, 64'h77, 64'd0, 4'd1, RNONE);
        W_stall = 1'b0; W_bubble = 1'b1;
        exp_m(64'd0, AOK);
        exp_w(AOK, PUSHQ, 64'h300, 64'd0, 4'd4, RNONE);
        exp_q.push_back(cur);

        drive("bubble_then_rst_store", AOK, RMMOVQ, 64'h400, 64'hDEADBEEFCAFEF00D, RNONE, RNONE);
        W_bubble = 1'b0; rst = 1'b1;
        exp_m(64'd0, AOK);
        exp_w(AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        exp_q.push_back(cur);

        drive("load_0x400_after_rst", AOK, MRMOVQ, 64'h400, 64'd0, RNONE, 4'd6);
        rst = 1'b0;
        exp_m(64'd0, AOK);
        exp_w(AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        exp_q.push_back(cur);

        drive("final_w", AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        exp_m(64'd0, AOK);
        exp_w(AOK, MRMOVQ, 64'h400, 64'd0, RNONE, 4'd6);
        exp_q.push_back(cur);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
